// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the pooling-unit scheduler:
//   - DEF_NUM_REQ / DEF_TIMEOUT : default core count and RUN-cycle budget
//   - CNT_W                     : width of the RUN timeout counter (TIMEOUT <= 65535)
//   - state_e                   : scheduler FSM state encoding
//   - idx_width()               : binary index width for a given core count
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RUN       = 3'd2,
    ST_RESP      = 3'd3,
    ST_DONE_WAIT = 3'd4
  } state_e;

  // Width of a binary index able to name every one of n requesters.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at index ptr and
// wraps modulo NUM_REQ; the first set request bit found wins.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index with highest priority this round (< NUM_REQ)
//   win     out NUM_REQ  one-hot winner (zero when no request)
//   win_idx out IDX_W    binary index of the winner (zero when no request)
//   valid   out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every signal written here gets a default at the top of the block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr and i are both below NUM_REQ, so one subtraction completes the wrap.
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid   = 1'b1;
        win_idx = cand;
      end
    end
    if (valid) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/pool_scheduler.sv
// -----------------------------------------------------------------------------
// pool_scheduler
// Shares one pooling unit between NUM_REQ cores. An idle scheduler grants the
// round-robin winner, pulses pool_start, waits for pool_done (or aborts after
// TIMEOUT RUN cycles), answers the owner with ack or err, and then waits for
// pool_done to fall before arbitrating again. All outputs are registered.
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        asynchronous reset, active low
//   req        in  NUM_REQ  per-core level request, held until ack/err
//   gnt        out NUM_REQ  one-hot owner of the pooling unit (or zero)
//   pool_sel   out IDX_W    binary index of the owner; holds when gnt is zero
//   pool_start out 1        one-cycle start pulse to the pooling unit
//   pool_done  in  1        completion level from the pooling unit
//   ack        out NUM_REQ  one-cycle completion pulse to the owner
//   err        out NUM_REQ  one-cycle timeout pulse to the owner
//   busy       out 1        scheduler is not IDLE
// -----------------------------------------------------------------------------
module pool_scheduler
  import cnn_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   pool_sel,
  output logic               pool_start,
  input  logic               pool_done,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  // The counter starts at 0 on RUN entry, so the last allowed RUN cycle is
  // the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_e             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] gnt_d, ack_d, err_d;
  logic [IDX_W-1:0]   sel_d;
  logic               start_d, busy_d;

  logic [NUM_REQ-1:0] arb_win;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Next-state and next-output logic. Outputs are computed here one cycle
  // early and registered below, so every port comes straight from a flop.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = gnt;
    sel_d   = pool_sel;
    start_d = 1'b0;
    ack_d   = '0;
    err_d   = '0;

    case (state)
      ST_IDLE: begin
        // pool_done is deliberately not looked at here.
        if (arb_valid) begin
          state_d = ST_START;
          gnt_d   = arb_win;
          sel_d   = arb_idx;
          start_d = 1'b1;
        end
      end

      ST_START: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end

      ST_RUN: begin
        // Done is tested first so it wins over a coinciding timeout. The
        // owner's req is not consulted: a dropped request still gets answered.
        if (pool_done) begin
          state_d = ST_RESP;
          ack_d   = gnt;
        end else if (cnt == TIMEOUT_M1) begin
          state_d = ST_RESP;
          err_d   = gnt;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_DONE_WAIT;
        gnt_d   = '0;
        ptr_d   = (pool_sel == LAST_IDX) ? '0 : pool_sel + 1'b1;
      end

      ST_DONE_WAIT: begin
        // A done level left over from this job must not reach the next RUN.
        if (!pool_done) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      pool_sel   <= '0;
      pool_start <= 1'b0;
      ack        <= '0;
      err        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      cnt        <= cnt_d;
      gnt        <= gnt_d;
      pool_sel   <= sel_d;
      pool_start <= start_d;
      ack        <= ack_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule
